vga_vram_arbiter: RTL and testbench
===================================

# vga_vram_arbiter

Shares the single-port video RAM between the CPU bus and the VGA scan-out path. It prefetches display words sequentially from a frame base address into a small FIFO and serves the VGA shifter on demand. It fits CPU reads and writes into the remaining memory cycles, with a low-water guarantee that keeps the display fed. It sits between the VGA timing generator / pixel shifter, the CPU data bus, and the VRAM block.

## Interface
- AW, 16, VRAM word-address width
- DW, 16, VRAM data width (16 pixels per word at 1 bpp)
- FIFO_DEPTH, 4, display prefetch FIFO entries (power of two)
- LOW_WATER, 2, display has priority while committed level < LOW_WATER
- FRAME_WORDS, 19200, words fetched per frame (640*480/16)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of the vertical back porch
- base_addr  in  AW  frame base word address, sampled on frame_start
- pix_pop  in  1  shifter consumes the head word
- pix_data  out  DW  FIFO head word
- pix_valid  out  1  FIFO non-empty
- underrun  out  1  one-cycle pulse when pix_pop occurs while empty
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid with cpu_ack, held until next read ack
- mem_en  out  1  VRAM access strobe
- mem_we  out  1  VRAM write enable
- mem_addr  out  AW  VRAM address
- mem_wdata  out  DW  VRAM write data
- mem_rdata  in  DW  VRAM read data, valid one cycle after a mem_en read

## Operation
- At most one memory access per cycle. The grant is registered into the mem_* outputs.
- Committed level = FIFO count + in-flight display reads. A display fetch is eligible when committed level < FIFO_DEPTH and fetched words < FRAME_WORDS.
- Priority each cycle:
  - display if eligible and committed level < LOW_WATER;
  - else CPU if cpu_req and no CPU access outstanding;
  - else display if eligible;
  - else idle (mem_en = 0).
- Display fetch: mem_addr = fetch pointer. The pointer increments by 1 per issue and wraps modulo 2^AW. The returning mem_rdata is pushed into the FIFO.
- CPU access:
  - Issued in cycle N.
  - Read data is captured from mem_rdata at N+1.
  - cpu_ack pulses at N+2 for both reads and writes.
  - cpu_busy is set from issue until ack, so a held cpu_req is not reissued.
  - The CPU drops cpu_req the cycle after cpu_ack or starts a new request.
- frame_start:
  - flushes the FIFO;
  - kills any in-flight display read (its data is discarded, not pushed);
  - loads the fetch pointer from base_addr;
  - clears the word counter.
  - An in-flight CPU access completes normally.
- frame_start with pix_pop in the same cycle: the flush wins, no pop, no underrun.
- Push and pop in the same cycle: the count is unchanged. When empty, a pop in the same cycle as a push is an underrun (no bypass).
- Pop on empty: underrun pulse, pix_data holds its last value, count stays 0.
- After FRAME_WORDS fetches, display fetching stops until the next frame_start. The CPU then gets every cycle.
- Reset: FIFO empty, pointer 0, counter 0, no in-flight accesses. All outputs are 0.

## Timing
- Display fetch latency: issue N → FIFO push N+1 → pix_valid N+2 (pix_valid reflects the registered count).
- CPU latency is fixed at 2 cycles from issue when granted. Worst-case CPU wait is bounded by FIFO_DEPTH − LOW_WATER + 1 grant cycles after a refill burst.
- Display consumption of at most 1 word per 64 clk (pixel rate clk/4, 16 px/word) cannot starve the CPU: the CPU is granted whenever committed level ≥ LOW_WATER.
- Reset is asynchronous assert, synchronous deassert (external synchronizer). Asserting rst_n mid-access drops the access with no ack.

## Structure
- Package vga_pkg holds:
  - the display constants HPIXELS = 800, VLINES = 521, HBP = 144, HFP = 784, VBP = 31, VFP = 511;
  - FRAME_WORDS;
  - the grant enum {GNT_IDLE, GNT_DISP, GNT_CPU}.
- Sub-module vga_fifo: synchronous FIFO parameterized by DW and FIFO_DEPTH, with push/pop/flush/count, registered head.
- The top level holds the arbiter, fetch pointer, word counter, in-flight tag pipeline, and CPU response registers.

## Test plan
- After reset, with no frame_start: all outputs are 0 and mem_en stays 0 even with cpu_req idle.
- frame_start with base_addr = 0x1000, no pops: four display reads to 0x1000–0x1003 on consecutive cycles. pix_valid rises 2 cycles after the first issue. mem_en then idles.
- CPU write to 0x0005 = 0xBEEF, then a read of 0x0005 while the FIFO is full: both granted immediately, cpu_ack at N+2 each, cpu_rdata = 0xBEEF.
- cpu_req held continuously while popping every cycle: display wins whenever committed level < 2. Every CPU request is still acked. No underrun once the FIFO is primed.
- frame_start while a display read is in flight: that word is never pushed. The next fetch uses the new base_addr, and the FIFO count reads 0 the following cycle.
- FRAME_WORDS = 8 override, pop 8 words, then pop once more: exactly 8 fetches. The 9th pop gives an underrun pulse and pix_data is unchanged.

Source files
------------

// File: rtl/vga_vram_arbiter_pkg.sv
// vga_pkg: display timing constants, frame size and arbiter grant encoding
package vga_pkg;

  localparam int HPIXELS     = 800;
  localparam int VLINES      = 521;
  localparam int HBP         = 144;
  localparam int HFP         = 784;
  localparam int VBP         = 31;
  localparam int VFP         = 511;
  localparam int FRAME_WORDS = 19200;

  typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_CPU} gnt_e;

endpackage

// File: rtl/vga_vram_arbiter_fifo.sv
// vga_fifo: display prefetch FIFO with flush, occupancy count and registered head word
module vga_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q, rd_nxt;
  logic [PW:0]   count_q;
  logic [DW-1:0] head_q, head_d;
  logic          empty, full, do_push, do_pop;

  // pop on empty is ignored; the head only changes when a word moves into the head slot
  always_comb begin
    empty   = count_q == '0;
    full    = count_q == (PW+1)'(DEPTH);
    do_pop  = pop_i & ~empty & ~flush_i;
    do_push = push_i & ~flush_i & (~full | do_pop);
    rd_nxt  = rd_q + 1'b1;
    head_d  = do_pop ? (count_q > (PW+1)'(1) ? mem_q[rd_nxt] : do_push ? wdata_i : head_q)
                     : (empty & do_push) ? wdata_i : head_q;
  end

  // word storage, contents only meaningful between rd and wr pointers
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;

  // pointers and count; flush empties the FIFO but leaves the last head word visible
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_nxt;
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      head_q  <= head_d;
    end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares single-port VRAM between display prefetch and CPU accesses
module vga_vram_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOW_WATER   = 2,
  parameter int FRAME_WORDS = vga_pkg::FRAME_WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic [AW-1:0] base_addr,
  input  logic          pix_pop,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          underrun,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  import vga_pkg::*;

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int CLW  = CNTW + 1;
  localparam int WCW  = $clog2(FRAME_WORDS + 1);

  logic [CNTW-1:0] fifo_cnt;
  logic [CLW-1:0]  committed;
  logic            eligible, starving, cpu_ok;
  gnt_e            gnt_d;

  logic            active_q;
  logic [AW-1:0]   ptr_q;
  logic [WCW-1:0]  wcnt_q;
  logic            iss_disp_q, ret_disp_q, iss_cpu_q, ret_cpu_q, ret_rd_q;
  logic            cpu_busy_q, cpu_ack_q, underrun_q;
  logic [DW-1:0]   cpu_rdata_q;
  logic            mem_en_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;

  vga_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (frame_start),
    .push_i  (ret_disp_q),
    .pop_i   (pix_pop),
    .wdata_i (mem_rdata),
    .head_o  (pix_data),
    .count_o (fifo_cnt)
  );

  // committed level counts words already queued plus display reads still in the memory pipe;
  // no display grant in a frame_start cycle since the pointer is being reloaded
  always_comb begin
    committed = CLW'(fifo_cnt) + CLW'(iss_disp_q) + CLW'(ret_disp_q);
    eligible  = active_q & ~frame_start & (committed < CLW'(FIFO_DEPTH)) & (wcnt_q < WCW'(FRAME_WORDS));
    starving  = committed < CLW'(LOW_WATER);
    cpu_ok    = cpu_req & ~cpu_busy_q;
    gnt_d     = (eligible & starving) ? GNT_DISP : cpu_ok ? GNT_CPU : eligible ? GNT_DISP : GNT_IDLE;
  end

  // register the grant onto the memory port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= gnt_d != GNT_IDLE;
      mem_we_q <= (gnt_d == GNT_CPU) & cpu_we;
      if (gnt_d == GNT_DISP) mem_addr_q <= ptr_q;
      else if (gnt_d == GNT_CPU) begin
        mem_addr_q  <= cpu_addr;
        mem_wdata_q <= cpu_wdata;
      end
    end

  // fetch pointer and per-frame word counter; fetching stays off until the first frame_start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active_q <= 1'b0;
      ptr_q    <= '0;
      wcnt_q   <= '0;
    end else if (frame_start) begin
      active_q <= 1'b1;
      ptr_q    <= base_addr;
      wcnt_q   <= '0;
    end else if (gnt_d == GNT_DISP) begin
      ptr_q  <= ptr_q + 1'b1;
      wcnt_q <= wcnt_q + 1'b1;
    end

  // tag pipeline and CPU response; frame_start kills the display read about to return
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      iss_disp_q  <= 1'b0;
      ret_disp_q  <= 1'b0;
      iss_cpu_q   <= 1'b0;
      ret_cpu_q   <= 1'b0;
      ret_rd_q    <= 1'b0;
      cpu_busy_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      iss_disp_q <= gnt_d == GNT_DISP;
      ret_disp_q <= iss_disp_q & ~frame_start;
      iss_cpu_q  <= gnt_d == GNT_CPU;
      ret_cpu_q  <= iss_cpu_q;
      ret_rd_q   <= iss_cpu_q & ~mem_we_q;
      cpu_ack_q  <= ret_cpu_q;
      cpu_busy_q <= (gnt_d == GNT_CPU) | (cpu_busy_q & ~cpu_ack_q);
      if (ret_rd_q) cpu_rdata_q <= mem_rdata;
      underrun_q <= pix_pop & ~frame_start & (fifo_cnt == '0);
    end

  assign pix_valid = fifo_cnt != '0;
  assign underrun  = underrun_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed checks of display prefetch, CPU access and frame handling
module tb_vga_vram_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, pix_pop = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] base_addr = '0, cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic [15:0] pix_data, cpu_rdata, mem_addr, mem_wdata;
  logic        pix_valid, underrun, cpu_ack, mem_en, mem_we;
  logic        wr_seen = 1'b0;
  logic [15:0] wr_addr = '0, wr_data = '0, last_disp = '0, hold;
  int          checks = 0, errors = 0, disp_n = 0, acks = 0, reqs = 0, pops = 0;

  always #5 clk = ~clk;

  vga_vram_arbiter #(.FRAME_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .base_addr(base_addr),
    .pix_pop(pix_pop), .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // VRAM model: background pattern plus the one CPU-written word
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        wr_seen <= 1'b1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end else mem_rdata <= (wr_seen && wr_addr == mem_addr) ? wr_data : pat(mem_addr);
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (mem_en && !mem_we && mem_addr >= 16'h1000) begin
      disp_n++;
      last_disp = mem_addr;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick;
    tick;
    check("rst pix_data", pix_data, 0);
    check("rst pix_valid", pix_valid, 0);
    check("rst underrun", underrun, 0);
    check("rst cpu_ack", cpu_ack, 0);
    check("rst cpu_rdata", cpu_rdata, 0);
    check("rst mem_en", mem_en, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("idle mem_en", mem_en, 0);
      check("idle pix_valid", pix_valid, 0);
    end

    base_addr = 16'h1000;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check("fs cycle mem_en", mem_en, 0);
    tick;
    check("fetch0 en", mem_en, 1);
    check("fetch0 addr", mem_addr, 16'h1000);
    check("fetch0 valid", pix_valid, 0);
    tick;
    check("fetch1 addr", mem_addr, 16'h1001);
    check("fetch1 valid", pix_valid, 0);
    tick;
    check("fetch2 addr", mem_addr, 16'h1002);
    check("fetch2 valid", pix_valid, 1);
    check("fetch2 head", pix_data, 16'h4A5A);
    tick;
    check("fetch3 en", mem_en, 1);
    check("fetch3 addr", mem_addr, 16'h1003);
    tick;
    check("full idle", mem_en, 0);

    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 16'h0005;
    cpu_wdata = 16'hBEEF;
    tick;
    check("wr en", mem_en, 1);
    check("wr we", mem_we, 1);
    check("wr addr", mem_addr, 16'h0005);
    check("wr data", mem_wdata, 16'hBEEF);
    check("wr ack early", cpu_ack, 0);
    tick;
    check("wr busy no reissue", mem_en, 0);
    check("wr ack N+1", cpu_ack, 0);
    tick;
    check("wr ack N+2", cpu_ack, 1);
    tick;
    check("wr ack pulse", cpu_ack, 0);
    cpu_we = 1'b0;
    tick;
    check("rd en", mem_en, 1);
    check("rd we", mem_we, 0);
    check("rd addr", mem_addr, 16'h0005);
    tick;
    check("rd ack N+1", cpu_ack, 0);
    tick;
    check("rd ack N+2", cpu_ack, 1);
    check("rd data", cpu_rdata, 16'hBEEF);
    cpu_req = 1'b0;
    tick;
    check("rd ack pulse", cpu_ack, 0);
    check("rd data held", cpu_rdata, 16'hBEEF);

    pix_pop = 1'b1;
    tick;
    pix_pop = 1'b0;
    check("pop head", pix_data, 16'h4A5B);
    check("pop no fetch yet", mem_en, 0);
    tick;
    check("refill en", mem_en, 1);
    check("refill addr", mem_addr, 16'h1004);
    base_addr = 16'h2000;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check("flush count", pix_valid, 0);
    check("flush mem_en", mem_en, 0);
    tick;
    check("new base en", mem_en, 1);
    check("new base addr", mem_addr, 16'h2000);
    check("killed word", pix_valid, 0);
    tick;
    check("new frame valid early", pix_valid, 0);
    tick;
    check("new frame valid", pix_valid, 1);
    check("new frame head", pix_data, 16'h7A5A);
    for (int i = 0; i < 4; i++) tick;

    disp_n = 0;
    pops = 0;
    acks = 0;
    reqs = 1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0100;
    for (int c = 0; c < 21; c++) begin
      check("mix underrun", underrun, 0);
      if (cpu_ack) begin
        check("mix rdata", cpu_rdata, pat(cpu_addr));
        acks++;
        cpu_addr = cpu_addr + 16'd1;
        reqs++;
      end
      if (c % 3 == 0) begin
        check("mix pop valid", pix_valid, 1);
        check("mix pop data", pix_data, pat(16'h2000 + 16'(pops)));
        pix_pop = 1'b1;
        pops++;
      end else pix_pop = 1'b0;
      tick;
    end
    pix_pop = 1'b0;
    for (int w = 0; w < 8 && !cpu_ack; w++) tick;
    check("mix final ack", cpu_ack, 1);
    check("mix final rdata", cpu_rdata, pat(cpu_addr));
    acks++;
    cpu_req = 1'b0;
    check("mix acks", acks, reqs);
    check("mix disp fetches", disp_n, 4);
    check("mix last fetch", last_disp, 16'h2007);

    base_addr = 16'h3000;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    disp_n = 0;
    pops = 0;
    for (int c = 0; c < 200 && pops < 8; c++) begin
      if (pix_valid) begin
        check("frame pop data", pix_data, pat(16'h3000 + 16'(pops)));
        pix_pop = 1'b1;
        pops++;
      end else pix_pop = 1'b0;
      tick;
    end
    pix_pop = 1'b0;
    check("frame pops", pops, 8);
    for (int i = 0; i < 4; i++) tick;
    check("frame fetches", disp_n, 8);
    check("frame last fetch", last_disp, 16'h3007);
    check("frame drained", pix_valid, 0);
    hold = pix_data;
    check("frame last head", hold, 16'h6A5D);
    pix_pop = 1'b1;
    check("underrun before edge", underrun, 0);
    tick;
    pix_pop = 1'b0;
    check("underrun pulse", underrun, 1);
    check("underrun data held", pix_data, 16'h6A5D);
    check("underrun still empty", pix_valid, 0);
    tick;
    check("underrun one cycle", underrun, 0);
    check("no 9th fetch", disp_n, 8);

    base_addr = 16'h4000;
    frame_start = 1'b1;
    pix_pop = 1'b1;
    tick;
    frame_start = 1'b0;
    pix_pop = 1'b0;
    check("flush beats pop", underrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
